// File: rtl/fpu_pkg.sv
// Shared FPU formats and the stage bundles of the pipelined subtractor.
// Used by fsub_pipe and fpu_lzc27.
package fpu_pkg;

  localparam int MANT_W = 23;
  localparam int DATA_W = 27;
  localparam logic [7:0] EXP_MAX = 8'hFF;
  localparam logic [31:0] QNAN_DEFAULT = 32'hFFC00000;
  localparam logic [4:0] SHIFT_SAT = 5'd31;

  typedef struct packed {
    logic              sign;
    logic [7:0]        exp;
    logic [MANT_W-1:0] man;
  } float_t;

  typedef struct packed {
    logic              sgn;
    logic              zsgn;
    logic              sub;
    logic              spec;
    logic [7:0]        exp;
    logic [DATA_W-1:0] ms;
    logic [DATA_W-1:0] mi;
    logic [31:0]       sres;
  } s12_t;

  typedef struct packed {
    logic              sgn;
    logic              zero;
    logic              spec;
    logic [7:0]        exp;
    logic [DATA_W-2:0] man;
    logic [31:0]       sres;
  } s23_t;

  function automatic logic [31:0] quiet(input logic [31:0] f);
    return f | 32'h0040_0000;
  endfunction

endpackage

// File: rtl/fpu_lzc27.sv
// Combinational 27-bit leading-zero counter, result 0..27.
// Shared between the FPU adder and subtractor.
module fpu_lzc27
  import fpu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  output logic [4:0]        cnt
);

  always_comb begin
    cnt = 5'd27;
    for (int i = 0; i < DATA_W; i++) begin
      if (a[i]) cnt = 5'(26 - i);
    end
  end

endmodule

// File: rtl/fsub_pipe.sv
// Three-stage IEEE-754 single subtractor, RNE, valid/ready handshake.
// Define FSUB_DENORM_EN for gradual underflow; otherwise flush-to-zero.
module fsub_pipe
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y,
  output logic        ovf
);

  logic v1, v2, v3;
  logic adv1, adv2, adv3;
  logic acc, en2, en3;
  s12_t r1, n1;
  s23_t r2, n2;

  assign adv3      = v3 && out_ready;
  assign en3       = !v3 || adv3;
  assign adv2      = v2 && en3;
  assign en2       = !v2 || adv2;
  assign adv1      = v1 && en2;
  assign in_ready  = !v1 || adv1;
  assign acc       = in_valid && in_ready;
  assign out_valid = v3;

  // S1: unpack, swap, align
  float_t f1, f2;
  logic nan1, nan2, inf1, inf2, sb, asup;
  logic [7:0] ea, eb, diff;
  logic [23:0] ma, mb, msup, minf;
  logic [4:0] sh;
  logic [57:0] wide;

  assign f1 = x1;
  assign f2 = x2;

  always_comb begin
    nan1 = (f1.exp == EXP_MAX) && (f1.man != '0);
    nan2 = (f2.exp == EXP_MAX) && (f2.man != '0);
    inf1 = (f1.exp == EXP_MAX) && (f1.man == '0);
    inf2 = (f2.exp == EXP_MAX) && (f2.man == '0);
    sb   = nan2 ? f2.sign : ~f2.sign;
    ea   = (f1.exp == 8'd0) ? 8'd1 : f1.exp;
    eb   = (f2.exp == 8'd0) ? 8'd1 : f2.exp;
`ifdef FSUB_DENORM_EN
    ma = {|f1.exp, f1.man};
    mb = {|f2.exp, f2.man};
`else
    ma = (f1.exp == 8'd0) ? 24'd0 : {1'b1, f1.man};
    mb = (f2.exp == 8'd0) ? 24'd0 : {1'b1, f2.man};
`endif
    // equal magnitudes make x2 the superior operand
    asup = (ea > eb) || ((ea == eb) && (ma > mb));
    msup = asup ? ma : mb;
    minf = asup ? mb : ma;
    diff = asup ? (ea - eb) : (eb - ea);
    sh   = (diff > {3'd0, SHIFT_SAT}) ? SHIFT_SAT : diff[4:0];
    wide = {minf, 34'd0} >> sh;

    n1.sgn  = asup ? f1.sign : sb;
    n1.zsgn = f1.sign & ~f2.sign;
    n1.sub  = f1.sign ^ sb;
    n1.exp  = asup ? ea : eb;
    n1.ms   = {msup, 3'b000};
    n1.mi   = {wide[57:32], |wide[31:0]};
    n1.spec = nan1 | nan2 | inf1 | inf2;
    unique case (1'b1)
      nan1:
        n1.sres = quiet(x1);
      (!nan1 && nan2):
        n1.sres = quiet(x2);
      (inf1 && !inf2 && !nan2):
        n1.sres = x1;
      (inf2 && !inf1 && !nan1):
        n1.sres = {~f2.sign, EXP_MAX, 23'd0};
      (inf1 && inf2):
        n1.sres = (f1.sign == f2.sign) ? QNAN_DEFAULT : x1;
      default:
        n1.sres = '0;
    endcase
  end

  // S2: add/sub, leading-zero count, normalize
  logic [27:0] sum;
  logic [26:0] m;
  logic [8:0] e9;
  logic [4:0] lz;

  fpu_lzc27 u_lzc (
    .a   (m),
    .cnt (lz)
  );

`ifdef FSUB_DENORM_EN
  logic [8:0] lim;
`else
  logic [9:0] en;
`endif

  always_comb begin
    if (r1.sub) sum = {1'b0, r1.ms - r1.mi};
    else        sum = {1'b0, r1.ms} + {1'b0, r1.mi};
    if (sum[27]) begin
      m  = {sum[27:2], |sum[1:0]};
      e9 = {1'b0, r1.exp} + 9'd1;
    end else begin
      m  = sum[26:0];
      e9 = {1'b0, r1.exp};
    end
    n2.sgn  = (m == '0) ? r1.zsgn : r1.sgn;
    n2.zero = (m == '0);
    n2.spec = r1.spec;
    n2.sres = r1.sres;
`ifdef FSUB_DENORM_EN
    // stop shifting at exponent 1 so the result lands as a subnormal
    lim = e9 - 9'd1;
    if ({4'd0, lz} > lim) begin
      n2.exp = 8'd0;
      n2.man = 26'(m << lim[4:0]);
    end else begin
      n2.exp = 8'(e9 - {4'd0, lz});
      n2.man = 26'(m << lz);
    end
`else
    en = {1'b0, e9} - {5'd0, lz};
    if (en[9] || (en == 10'd0)) n2.zero = 1'b1;
    n2.exp = en[7:0];
    n2.man = 26'(m << lz);
`endif
  end

  // S3: round, special-case mux, pack
  logic up, novf;
  logic [30:0] rr;
  logic [31:0] res;

  always_comb begin
    up = r2.man[2] & (r2.man[1] | r2.man[0] | r2.man[3]);
    // rounding carry ripples into the exponent field
    rr = {r2.exp, r2.man[25:3]} + {30'd0, up};
    if (r2.spec)                res = r2.sres;
    else if (r2.zero)           res = {r2.sgn, 31'd0};
    else if (r2.exp == EXP_MAX) res = {r2.sgn, EXP_MAX, 23'd0};
    else                        res = {r2.sgn, rr};
    novf = !r2.spec && (res[30:23] == EXP_MAX);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1  <= 1'b0;
      v2  <= 1'b0;
      v3  <= 1'b0;
      r1  <= '0;
      r2  <= '0;
      y   <= '0;
      ovf <= 1'b0;
    end else begin
      if (in_ready) v1 <= in_valid;
      if (acc) r1 <= n1;
      if (en2) v2 <= adv1;
      if (adv1) r2 <= n2;
      if (en3) v3 <= adv2;
      if (adv2) begin
        y   <= res;
        ovf <= novf;
      end
    end
  end

endmodule
